timer_6502: RTL and testbench

Memory-mapped 16-bit down-counting timer with 8-bit prescaler and interrupt, attached to the 6502 CPU bus as a peripheral alongside the IO and UART blocks. It takes the CPU address, write data and write strobe, and returns registered read data into the top-level read-data mux. Its irq_o is ORed into the CPU IRQ line. Firmware uses it for periodic ticks and delays.

---
 rtl/timer_6502.sv | 147 ++++++++++++++
 tb/tb_timer_6502.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/timer_6502.sv
// timer_6502: memory-mapped 16-bit down-counting timer for the 6502 bus.
// An 8-bit prescaler divides the clock into ticks that decrement COUNT.
// On expiry EXP is set and, with IRQEN, drives a level interrupt.
// The timer either reloads (CONT) or stops. Reads are registered,
// with one clock of latency.
module timer_6502 #(
  parameter int address_width = 16,
  parameter int data_width    = 8,
  parameter logic [address_width-1:0] BaseAddress = 'h9200
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [address_width-1:0] address_i,
  input  logic [data_width-1:0]    data_i,
  input  logic                     rd_wr_i,
  output logic [data_width-1:0]    data_o,
  output logic                     irq_o
);

  logic [address_width-1:0] addr_diff;
  logic [3:0]               off;
  logic                     hit, wr, rd;

  logic                      en, cont, irqen, exp;
  logic [2*data_width-1:0]   reload, count;
  logic [data_width-1:0]     shadow, prescale, pcnt;

  logic                      en_nxt, cont_nxt, irqen_nxt, exp_nxt;
  logic [2*data_width-1:0]   reload_nxt, count_nxt;
  logic [data_width-1:0]     shadow_nxt, prescale_nxt, pcnt_nxt;
  logic                      tick, expire;
  logic [data_width-1:0]     rdata;

  // Window decode: the upper bits of the offset must be zero for a hit.
  always_comb begin
    addr_diff = address_i - BaseAddress;
    off       = addr_diff[3:0];
    hit       = (address_i >= BaseAddress) && (addr_diff[address_width-1:4] == '0);
    wr        = hit && rd_wr_i;
    rd        = hit && !rd_wr_i;
  end

  // Next state: counting first, then bus writes, which override where they collide.
  always_comb begin
    en_nxt       = en;
    cont_nxt     = cont;
    irqen_nxt    = irqen;
    exp_nxt      = exp;
    reload_nxt   = reload;
    count_nxt    = count;
    shadow_nxt   = shadow;
    prescale_nxt = prescale;
    pcnt_nxt     = pcnt;
    tick         = 1'b0;
    expire       = 1'b0;

    if (en) begin
      if (pcnt == prescale) begin
        pcnt_nxt = '0;
        tick     = 1'b1;
      end else begin
        pcnt_nxt = pcnt + 1'b1;
      end
    end

    if (tick) begin
      if (count == '0) begin
        expire  = 1'b1;
        exp_nxt = 1'b1;
        if (cont) count_nxt = reload;
        else      en_nxt    = 1'b0;
      end else begin
        count_nxt = count - 1'b1;
      end
    end

    if (wr) begin
      case (off)
        4'h0: begin
          cont_nxt  = data_i[1];
          irqen_nxt = data_i[2];
          if (!data_i[0]) begin
            en_nxt = 1'b0;
          end else if (!en) begin
            // Start from idle: load the count and restart the prescaler.
            en_nxt    = 1'b1;
            count_nxt = reload;
            pcnt_nxt  = '0;
          end
        end
        // A same-edge expiry beats the write-1-to-clear.
        4'h1: if (data_i[0] && !expire) exp_nxt = 1'b0;
        4'h2: reload_nxt[data_width-1:0]            = data_i;
        4'h3: reload_nxt[2*data_width-1:data_width] = data_i;
        4'h6: prescale_nxt = data_i;
        default: ;
      endcase
    end

    // Latch the high byte that matches the low byte being returned.
    if (rd && off == 4'h4) shadow_nxt = count[2*data_width-1:data_width];
  end

  // Read mux over current (pre-update) register values.
  always_comb begin
    case (off)
      4'h0:    rdata = data_width'({irqen, cont, en});
      4'h1:    rdata = data_width'({en, exp});
      4'h2:    rdata = reload[data_width-1:0];
      4'h3:    rdata = reload[2*data_width-1:data_width];
      4'h4:    rdata = count[data_width-1:0];
      4'h5:    rdata = shadow;
      4'h6:    rdata = prescale;
      default: rdata = '0;
    endcase
  end

  // State registers, read data and interrupt flop.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      en       <= 1'b0;
      cont     <= 1'b0;
      irqen    <= 1'b0;
      exp      <= 1'b0;
      reload   <= '1;
      count    <= '0;
      shadow   <= '0;
      prescale <= '0;
      pcnt     <= '0;
      data_o   <= '0;
      irq_o    <= 1'b0;
    end else begin
      en       <= en_nxt;
      cont     <= cont_nxt;
      irqen    <= irqen_nxt;
      exp      <= exp_nxt;
      reload   <= reload_nxt;
      count    <= count_nxt;
      shadow   <= shadow_nxt;
      prescale <= prescale_nxt;
      pcnt     <= pcnt_nxt;
      irq_o    <= exp_nxt & irqen_nxt;
      if (rd) data_o <= rdata;
    end
  end

endmodule

// File: tb/tb_timer_6502.sv
// Directed bench for timer_6502: expected read data is queued when a read
// is issued and popped when data_o is sampled one clock later.
module tb_timer_6502;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] address_i;
  logic [7:0]  data_i;
  logic        rd_wr_i;
  logic [7:0]  data_o;
  logic        irq_o;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  localparam logic [15:0] IDLE = 16'h0000;

  timer_6502 dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .address_i (address_i),
    .data_i    (data_i),
    .rd_wr_i   (rd_wr_i),
    .data_o    (data_o),
    .irq_o     (irq_o)
  );

  always #5 clk_i = ~clk_i;

  // One clock edge, then settle away from it.
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%02h want=%02h", tag, got, want);
    end
  endtask

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    address_i = a;
    data_i    = d;
    rd_wr_i   = 1'b1;
    cyc();
    rd_wr_i   = 1'b0;
    address_i = IDLE;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] want, input string tag);
    logic [7:0] w;
    address_i = a;
    rd_wr_i   = 1'b0;
    exp_q.push_back(want);
    cyc();
    address_i = IDLE;
    w = exp_q.pop_front();
    check(tag, data_o, w);
  endtask

  task automatic chk_irq(input string tag, input logic want);
    check(tag, {7'b0, irq_o}, {7'b0, want});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_i   = 1'b1;
    address_i = IDLE;
    data_i    = 8'h00;
    rd_wr_i   = 1'b0;
    #12 reset_i = 1'b0;
    cyc();

    // Reset state
    check("rst_data", data_o, 8'h00);
    chk_irq("rst_irq", 1'b0);
    rd(16'h9200, 8'h00, "rst_ctrl");
    rd(16'h9201, 8'h00, "rst_status");
    rd(16'h9202, 8'hFF, "rst_rld_lo");
    rd(16'h9203, 8'hFF, "rst_rld_hi");
    rd(16'h9204, 8'h00, "rst_cnt_lo");
    rd(16'h9205, 8'h00, "rst_cnt_hi");
    rd(16'h9206, 8'h00, "rst_presc");
    rd(16'h9207, 8'h00, "rst_off7");

    // One-shot: RELOAD=3, PRESCALE=1 -> expiry 8 clocks after start
    wr(16'h9202, 8'h03);
    wr(16'h9203, 8'h00);
    wr(16'h9206, 8'h01);
    wr(16'h9200, 8'h05);
    repeat (7) cyc();
    chk_irq("os_irq_e7", 1'b0);
    cyc();
    chk_irq("os_irq_e8", 1'b1);
    rd(16'h9201, 8'h01, "os_status");
    rd(16'h9200, 8'h04, "os_ctrl");

    // Continuous mode, clear, re-expiry, clear colliding with expiry
    wr(16'h9201, 8'h01);
    chk_irq("clr_irq", 1'b0);
    wr(16'h9200, 8'h07);
    repeat (7) cyc();
    chk_irq("ct_irq_e7", 1'b0);
    cyc();
    chk_irq("ct_irq_e8", 1'b1);
    cyc();
    chk_irq("ct_irq_e9", 1'b1);
    wr(16'h9201, 8'h01);
    chk_irq("ct_clr_e10", 1'b0);
    repeat (5) cyc();
    chk_irq("ct_irq_e15", 1'b0);
    cyc();
    chk_irq("ct_irq_e16", 1'b1);
    repeat (7) cyc();
    wr(16'h9201, 8'h01);
    chk_irq("coll_irq_e24", 1'b1);
    wr(16'h9200, 8'h00);
    rd(16'h9201, 8'h01, "coll_status");
    rd(16'h9200, 8'h00, "stop_ctrl");
    wr(16'h9201, 8'h01);
    chk_irq("clr2_irq", 1'b0);

    // Coherent 16-bit count read with PRESCALE=0, RELOAD=0x1234
    wr(16'h9206, 8'h00);
    wr(16'h9202, 8'h34);
    wr(16'h9203, 8'h12);
    wr(16'h9200, 8'h01);
    repeat (10) cyc();
    rd(16'h9204, 8'h2A, "cnt_lo_a");
    rd(16'h9205, 8'h12, "cnt_hi_a");
    repeat (40) cyc();
    rd(16'h9204, 8'h00, "cnt_lo_borrow");
    rd(16'h9205, 8'h12, "cnt_hi_borrow");
    rd(16'h9204, 8'hFE, "cnt_lo_after");
    rd(16'h9205, 8'h11, "cnt_hi_after");
    wr(16'h9200, 8'h00);

    // Asynchronous reset in the middle of a continuous run
    wr(16'h9202, 8'h03);
    wr(16'h9203, 8'h00);
    wr(16'h9200, 8'h07);
    repeat (5) cyc();
    chk_irq("pre_rst_irq", 1'b1);
    rd(16'h9201, 8'h03, "pre_rst_status");
    #2 reset_i = 1'b1;
    #1;
    chk_irq("async_rst_irq", 1'b0);
    check("async_rst_data", data_o, 8'h00);
    #1 reset_i = 1'b0;
    cyc();
    rd(16'h9200, 8'h00, "post_rst_ctrl");
    rd(16'h9202, 8'hFF, "post_rst_rld");
    rd(16'h9201, 8'h00, "post_rst_status");
    repeat (10) cyc();
    chk_irq("post_rst_idle_irq", 1'b0);

    // Unmapped offsets and addresses outside the window
    wr(16'h9209, 8'h5A);
    rd(16'h9209, 8'h00, "off9");
    wr(16'h9212, 8'h11);
    wr(16'h9102, 8'h22);
    wr(16'h9300, 8'h01);
    rd(16'h9202, 8'hFF, "outside_rld");
    rd(16'h9200, 8'h00, "outside_ctrl");
    repeat (20) cyc();
    chk_irq("outside_irq", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
